// File: rtl/div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : div_datapath
// Description : Repeated-subtraction divider datapath. Holds the working
//               remainder (r1), divisor (r2), remainder result (r3), step
//               counter (r4) and quotient result (r5). An external controller
//               sequences load / step / capture through reset_regs, sel_r1,
//               sel_r5 and en, and watches cmp_res / nor_res to decide when
//               to stop stepping.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock, all state updates on rising edge
//   rst_n        in   1      synchronous active-low reset
//   a_in         in   WIDTH  dividend, sampled on load
//   b_in         in   WIDTH  divisor, sampled on load
//   reset_regs   in   1      0 = load operands, 1 = hold/compute
//   sel_r1       in   1      1 = r1 <= r1 - r2 on a step, 0 = hold r1
//   sel_r5       in   1      1 = capture quotient/remainder
//   en           in   1      step enable for r1/r4/r5 updates
//   cmp_res      out  1      r1 < r2 (unsigned), combinational
//   nor_res      out  1      divisor is zero, combinational
//   quotient     out  WIDTH  registered quotient result (r5)
//   remainder    out  WIDTH  registered remainder result (r3)
//   result_valid out  1      one-cycle pulse after each capture
//   div_zero     out  1      sticky divide-by-zero flag
// ============================================================================
module div_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             reset_regs,
  input  logic             sel_r1,
  input  logic             sel_r5,
  input  logic             en,
  output logic             cmp_res,
  output logic             nor_res,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Architectural registers
  logic [WIDTH-1:0] r1;   // working remainder
  logic [WIDTH-1:0] r2;   // divisor
  logic [WIDTH-1:0] r3;   // remainder result
  logic [WIDTH-1:0] r4;   // step counter
  logic [WIDTH-1:0] r5;   // quotient result
  logic             valid_q;
  logic             div_zero_q;

  // Next-state values
  logic [WIDTH-1:0] r1_next;
  logic [WIDTH-1:0] r2_next;
  logic [WIDTH-1:0] r3_next;
  logic [WIDTH-1:0] r4_next;
  logic [WIDTH-1:0] r5_next;
  logic             valid_next;
  logic             div_zero_next;

  // Decoded operations
  logic             do_load;
  logic             do_capture;
  logic             do_step;

  // Datapath helpers
  logic [WIDTH-1:0] r1_minus_r2;
  logic [WIDTH-1:0] r4_inc_sat;

  // --------------------------------------------------------------------------
  // Status flags: purely combinational from the current r1/r2 so the
  // controller sees them in the same cycle the registers change.
  // --------------------------------------------------------------------------
  assign cmp_res = (r1 < r2);
  assign nor_res = ~|r2;

  // --------------------------------------------------------------------------
  // Operation decode. Load has priority over everything; capture has priority
  // over stepping when both selects are high.
  // --------------------------------------------------------------------------
  assign do_load    = ~reset_regs;
  assign do_capture = reset_regs & en & sel_r5;
  assign do_step    = reset_regs & en & ~sel_r5 & sel_r1;

  // Subtraction wraps modulo 2^WIDTH; the counter saturates instead of
  // wrapping so an over-stepped division never reports a small quotient.
  assign r1_minus_r2 = r1 - r2;
  assign r4_inc_sat  = (r4 == ALL_ONES) ? r4 : (r4 + ONE);

  always_comb begin
    r1_next       = r1;
    r2_next       = r2;
    r3_next       = r3;
    r4_next       = r4;
    r5_next       = r5;
    valid_next    = 1'b0;
    div_zero_next = div_zero_q;

    if (do_load) begin
      r1_next       = a_in;
      r2_next       = b_in;
      r4_next       = '0;
      div_zero_next = 1'b0;
    end else if (do_capture) begin
      r3_next    = r1;
      valid_next = 1'b1;
      if (nor_res) begin
        // Divide by zero: flag it and report an all-ones quotient.
        r5_next       = ALL_ONES;
        div_zero_next = 1'b1;
      end else begin
        r5_next = r4;
      end
    end else if (do_step) begin
      r1_next = r1_minus_r2;
      r4_next = r4_inc_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1         <= '0;
      r2         <= '0;
      r3         <= '0;
      r4         <= '0;
      r5         <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      r1         <= r1_next;
      r2         <= r2_next;
      r3         <= r3_next;
      r4         <= r4_next;
      r5         <= r5_next;
      valid_q    <= valid_next;
      div_zero_q <= div_zero_next;
    end
  end

  assign quotient     = r5;
  assign remainder    = r3;
  assign result_valid = valid_q;
  assign div_zero     = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_datapath
// Description : Self-checking bench for div_datapath (WIDTH = 8). Directed
//               scenarios followed by random divisions compared against
//               plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_datapath;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             reset_regs;
  logic             sel_r1;
  logic             sel_r5;
  logic             en;
  logic             cmp_res;
  logic             nor_res;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             result_valid;
  logic             div_zero;

  int vectors;
  int miscompares;

  div_datapath #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_in         (a_in),
    .b_in         (b_in),
    .reset_regs   (reset_regs),
    .sel_r1       (sel_r1),
    .sel_r5       (sel_r5),
    .en           (en),
    .cmp_res      (cmp_res),
    .nor_res      (nor_res),
    .quotient     (quotient),
    .remainder    (remainder),
    .result_valid (result_valid),
    .div_zero     (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one set of controls across one rising edge, then settle.
  task automatic cycle(input logic rn, input logic rr, input logic s1,
                       input logic s5, input logic e);
    rst_n      = rn;
    reset_regs = rr;
    sel_r1     = s1;
    sel_r5     = s5;
    en         = e;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int b);
    a_in = WIDTH'(a);
    b_in = WIDTH'(b);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic capture();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Full division transaction checked against integer arithmetic.
  // Random hold cycles are sprinkled in; they must not disturb the result.
  task automatic divide(input string tag, input int a, input int b);
    int q;
    int r;
    q = (b == 0) ? MAXV : a / b;
    r = (b == 0) ? a : a % b;
    load(a, b);
    check({tag, ".nor"}, nor_res, (b == 0));
    check({tag, ".cmp_load"}, cmp_res, (a < b));
    if (b != 0) begin
      for (int k = 0; k < q; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
          else                           idle();
        end
        check({tag, ".cmp_step"}, cmp_res, 0);
        step();
      end
      check({tag, ".cmp_done"}, cmp_res, 1);
    end
    capture();
    check({tag, ".quot"}, quotient, q);
    check({tag, ".rem"}, remainder, r);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".dz"}, div_zero, (b == 0));
    idle();
    check({tag, ".valid_drop"}, result_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    a_in        = '0;
    b_in        = '0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.quot", quotient, 0);
    check("rst.rem", remainder, 0);
    check("rst.valid", result_valid, 0);
    check("rst.dz", div_zero, 0);
    check("rst.nor", nor_res, 1);
    check("rst.cmp", cmp_res, 0);

    // 23 / 5 with explicit step count
    load(23, 5);
    check("d23.cmp_load", cmp_res, 0);
    repeat (4) step();
    check("d23.cmp_before_cap", cmp_res, 1);
    check("d23.valid_before", result_valid, 0);
    capture();
    check("d23.quot", quotient, 4);
    check("d23.rem", remainder, 3);
    check("d23.valid", result_valid, 1);
    idle();
    check("d23.valid_pulse_end", result_valid, 0);

    // Results stay put across a new load and while held
    load(100, 3);
    check("hold.quot_after_load", quotient, 4);
    check("hold.rem_after_load", remainder, 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("hold.cmp_after_noop", cmp_res, 0);
    check("hold.valid_noop", result_valid, 0);

    // Divide by zero
    load(7, 0);
    check("dz.nor", nor_res, 1);
    capture();
    check("dz.flag", div_zero, 1);
    check("dz.quot", quotient, 8'hFF);
    check("dz.rem", remainder, 7);
    idle();
    check("dz.sticky", div_zero, 1);
    load(9, 2);
    check("dz.cleared_by_load", div_zero, 0);

    // Dividend smaller than divisor
    load(3, 9);
    check("small.cmp", cmp_res, 1);
    capture();
    check("small.quot", quotient, 0);
    check("small.rem", remainder, 3);

    // Back-to-back captures give consecutive pulses
    capture();
    check("b2b.valid1", result_valid, 1);
    capture();
    check("b2b.valid2", result_valid, 1);
    idle();
    check("b2b.valid_end", result_valid, 0);

    // Reset aborts a division in progress and overrides a capture request
    load(200, 7);
    repeat (10) step();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("abort.quot", quotient, 0);
    check("abort.rem", remainder, 0);
    check("abort.valid", result_valid, 0);
    check("abort.dz", div_zero, 0);
    check("abort.nor", nor_res, 1);
    check("abort.cmp", cmp_res, 0);
    idle();
    check("abort.valid_after", result_valid, 0);

    // Counter saturation: 260 steps of 255 / 1
    load(255, 1);
    repeat (260) step();
    capture();
    check("sat.quot", quotient, 255);
    check("sat.rem", remainder, 251);   // 255 - 260 mod 256

    // Random divisions
    for (int t = 0; t < 40; t++) begin
      int a;
      int b;
      a = int'($urandom_range(0, MAXV));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAXV));
      if (t < 6) b = int'($urandom_range(1, 4));   // long step sequences
      divide("rnd", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_datapath.md
DIV_DATAPATH -- requirements
Module: div_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port a_in  input  WIDTH  dividend, sampled on load.
REQ-005 SHALL have port b_in  input  WIDTH  divisor, sampled on load.
REQ-006 SHALL have port reset_regs  input  1  from controller; 0 = load operands, 1 = hold/compute.
REQ-007 SHALL have port sel_r1  input  1  r1 source select; 1 = r1 - r2, 0 = hold r1.
REQ-008 SHALL have port sel_r5  input  1  1 = capture quotient/remainder into result registers.
REQ-009 SHALL have port en  input  1  step enable for r1/r4/r5 updates.
REQ-010 SHALL have port cmp_res  output  1  combinational, 1 when r1 < r2 (unsigned).
REQ-011 SHALL have port nor_res  output  1  combinational, NOR of all r2 bits (divisor zero).
REQ-012 SHALL have port quotient  output  WIDTH  registered result quotient (r5).
REQ-013 SHALL have port remainder  output  WIDTH  registered result remainder (r3).
REQ-014 SHALL have port result_valid  output  1  one-cycle pulse when results update.
REQ-015 SHALL have port div_zero  output  1  sticky flag, set by divide-by-zero capture.

Function
REQ-016 SHALL hold r1 working remainder, r2 divisor, r3 remainder result, r4 step counter, r5 quotient result, all WIDTH bits.
REQ-017 SHALL on edge with reset_regs=0: r1<=a_in, r2<=b_in, r4<=0, clear div_zero; r3/r5 unchanged; priority over en/sel_*.
REQ-018 SHALL on edge with reset_regs=1, en=1, sel_r5=0, sel_r1=1: r1<=r1-r2 (mod 2^WIDTH), r4<=r4+1.
REQ-019 SHALL saturate r4 at 2^WIDTH-1; no wrap to 0.
REQ-020 SHALL on edge with reset_regs=1, en=1, sel_r5=1: r5<=r4, r3<=r1, result_valid=1 next cycle; r1/r4 unchanged.
REQ-021 SHALL set div_zero on a capture (REQ-020) where nor_res=1, and force r5 to all-ones, r3 to r1 in that case.
REQ-022 SHALL hold all registers when en=0 and reset_regs=1, or when en=1, sel_r5=0, sel_r1=0.
REQ-023 SHALL drive result_valid high exactly one cycle per capture; back-to-back captures give consecutive pulses.
REQ-024 SHALL derive cmp_res/nor_res from current r1/r2 only, zero input-to-flag latency.
REQ-025 SHALL deliver quotient=floor(a/b), remainder=a mod b when stepped while cmp_res=0 and captured at first cmp_res=1; latency = quotient+1 steps after load.
REQ-026 SHALL keep quotient/remainder stable between captures, including across new loads.

Reset
REQ-027 SHALL on rising edge with rst_n=0 clear r1..r5, result_valid, div_zero to 0, overriding all other inputs.
REQ-028 SHALL abort a division in progress on reset; after release flags read cmp_res=0 (0<0 false), nor_res=1.
REQ-029 SHALL resume normal operation on the first edge with rst_n=1.

Verification
REQ-030 SHALL cover: rst_n=0 one cycle -> quotient=0, remainder=0, result_valid=0, div_zero=0, nor_res=1.
REQ-031 SHALL cover: load a=23,b=5, 4 steps, capture -> quotient=4, remainder=3, result_valid one-cycle pulse, cmp_res=1 before capture.
REQ-032 SHALL cover: load a=7,b=0, capture -> div_zero=1, quotient=0xFF, remainder=7 (WIDTH=8).
REQ-033 SHALL cover: load a=3,b=9 -> cmp_res=1 immediately; capture -> quotient=0, remainder=3.
REQ-034 SHALL cover: load a=200,b=7, 10 steps, rst_n=0 one cycle -> all registers 0, no result_valid pulse.
REQ-035 SHALL cover: load a=255,b=1, 260 steps -> r4 saturates, captured quotient=255.
